// File: rtl/sdram_mem_ctrl.sv
// -----------------------------------------------------------------------------
// sdram_mem_ctrl
//   Single-port SDRAM stand-in that sits behind the cache's SDRAM interface.
//   After reset it fills its array with a known pattern (mem[i] = i, truncated or
//   zero-extended to DATA_WIDTH). It then serves one word access per strobe
//   cycle, with a fixed read latency. It also keeps saturating access counters
//   and a sticky protocol-error flag.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   Address_sdram  word address from the cache; only the low MEM_AW bits are used
//   din_sdram      write data
//   wr_rd_sdram    1 = write, 0 = read; qualified by mstrb_sdram
//   mstrb_sdram    access strobe; one word access per cycle it is high
//   DOut_sdram     read data; holds the last read word between pulses
//   dout_valid     one-cycle pulse marking new data on DOut_sdram
//   init_done      array fill finished; accesses are accepted
//   rd_count       accepted reads, saturating
//   wr_count       accepted writes, saturating
//   err_sticky     a strobe arrived before init_done; cleared only by rst
// -----------------------------------------------------------------------------
module sdram_mem_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_AW     = 10,
    parameter int READ_LAT   = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] Address_sdram,
    input  logic [DATA_WIDTH-1:0] din_sdram,
    input  logic                  wr_rd_sdram,
    input  logic                  mstrb_sdram,
    output logic [DATA_WIDTH-1:0] DOut_sdram,
    output logic                  dout_valid,
    output logic                  init_done,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  wr_count,
    output logic                  err_sticky
);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t                 state_reg;
    logic [MEM_AW-1:0]      init_idx_reg;
    logic                   init_done_reg;
    logic                   err_sticky_reg;
    logic [CNT_WIDTH-1:0]   rd_count_reg;
    logic [CNT_WIDTH-1:0]   wr_count_reg;

    logic [DATA_WIDTH-1:0]  mem [0:(1 << MEM_AW)-1];

    // Stage 0 is the registered array read at the strobe edge. Stage k is
    // loaded k edges later, and stage READ_LAT drives the outputs. Each stage's
    // data only moves along with a valid word, so the last stage holds the
    // most recent read value while no new word arrives.
    logic [DATA_WIDTH-1:0]  pipe_data_reg [0:READ_LAT];
    logic [READ_LAT:0]      pipe_valid_reg;

    logic [MEM_AW-1:0]      idx;
    logic                   access_ok;
    logic                   rd_fire;
    logic                   wr_fire;
    logic                   mem_we;
    logic [MEM_AW-1:0]      mem_waddr;
    logic [DATA_WIDTH-1:0]  mem_wdata;
    logic [DATA_WIDTH-1:0]  init_data;

    // The upper address bits alias onto the same storage.
    assign idx = Address_sdram[MEM_AW-1:0];

    generate
        if (ADDR_WIDTH > MEM_AW) begin : g_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^Address_sdram[ADDR_WIDTH-1:MEM_AW];
        end

        if (MEM_AW >= DATA_WIDTH) begin : g_init_trunc
            assign init_data = init_idx_reg[DATA_WIDTH-1:0];
        end else begin : g_init_zext
            assign init_data = {{(DATA_WIDTH-MEM_AW){1'b0}}, init_idx_reg};
        end
    endgenerate

    assign access_ok = mstrb_sdram && (state_reg == ST_READY) && !rst;
    assign rd_fire   = access_ok && !wr_rd_sdram;
    assign wr_fire   = access_ok &&  wr_rd_sdram;

    // The single write port is shared between the init fill and cache writes.
    // The two sources never overlap because they belong to different states.
    assign mem_we    = !rst && ((state_reg == ST_INIT) || wr_fire);
    assign mem_waddr = (state_reg == ST_INIT) ? init_idx_reg : idx;
    assign mem_wdata = (state_reg == ST_INIT) ? init_data    : din_sdram;

    // Storage array: no reset, so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid_reg <= '0;
            for (int k = 0; k <= READ_LAT; k++) begin
                pipe_data_reg[k] <= '0;
            end
        end else begin
            pipe_valid_reg[0] <= rd_fire;
            if (rd_fire) begin
                pipe_data_reg[0] <= mem[idx];
            end
            for (int k = 1; k <= READ_LAT; k++) begin
                pipe_valid_reg[k] <= pipe_valid_reg[k-1];
                if (pipe_valid_reg[k-1]) begin
                    pipe_data_reg[k] <= pipe_data_reg[k-1];
                end
            end
        end
    end

    // Control FSM, statistics and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_INIT;
            init_idx_reg   <= '0;
            init_done_reg  <= 1'b0;
            err_sticky_reg <= 1'b0;
            rd_count_reg   <= '0;
            wr_count_reg   <= '0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    // Strobes during the fill are dropped and flagged.
                    if (mstrb_sdram) begin
                        err_sticky_reg <= 1'b1;
                    end
                    init_idx_reg <= init_idx_reg + 1'b1;
                    if (init_idx_reg == {MEM_AW{1'b1}}) begin
                        state_reg     <= ST_READY;
                        init_done_reg <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (wr_fire && (wr_count_reg != {CNT_WIDTH{1'b1}})) begin
                        wr_count_reg <= wr_count_reg + 1'b1;
                    end
                    if (rd_fire && (rd_count_reg != {CNT_WIDTH{1'b1}})) begin
                        rd_count_reg <= rd_count_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_INIT;
                end
            endcase
        end
    end

    assign DOut_sdram = pipe_data_reg[READ_LAT];
    assign dout_valid = pipe_valid_reg[READ_LAT];
    assign init_done  = init_done_reg;
    assign rd_count   = rd_count_reg;
    assign wr_count   = wr_count_reg;
    assign err_sticky = err_sticky_reg;

endmodule
